// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master to one-slave pipelined Wishbone arbiter with outstanding-transfer limit
// Optional round-robin arbitration: define WB_ARB_ROUND_ROBIN_EN (default build is fixed priority, m0 first).
module wb_arbiter2 #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADR_W           = 16,
    parameter int DAT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             m0_cyc,
    input  logic             m0_stb,
    input  logic             m0_we,
    input  logic [ADR_W-1:0] m0_adr,
    input  logic [DAT_W-1:0] m0_wdat,
    output logic [DAT_W-1:0] m0_rdat,
    output logic             m0_ack,
    output logic             m0_stall,

    input  logic             m1_cyc,
    input  logic             m1_stb,
    input  logic             m1_we,
    input  logic [ADR_W-1:0] m1_adr,
    input  logic [DAT_W-1:0] m1_wdat,
    output logic [DAT_W-1:0] m1_rdat,
    output logic             m1_ack,
    output logic             m1_stall,

    output logic             s_cyc,
    output logic             s_stb,
    output logic             s_we,
    output logic [ADR_W-1:0] s_adr,
    output logic [DAT_W-1:0] s_wdat,
    input  logic [DAT_W-1:0] s_rdat,
    input  logic             s_ack,
    input  logic             s_stall
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          last, last_nx;
    logic          full, accept, sel;
    logic          o_cyc, o_stb, o_we;
    logic [ADR_W-1:0] o_adr;
    logic [DAT_W-1:0] o_wdat;

    assign m0_rdat = s_rdat;
    assign m1_rdat = s_rdat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            last  <= last_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        last_nx  = last;
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_wdat   = '0;
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;
        m0_stall = 1'b1;
        m1_stall = 1'b1;
        full     = (cnt == CNT_MAX);
        accept   = 1'b0;
        sel      = (state == GNT1);
        o_cyc    = sel ? m1_cyc  : m0_cyc;
        o_stb    = sel ? m1_stb  : m0_stb;
        o_we     = sel ? m1_we   : m0_we;
        o_adr    = sel ? m1_adr  : m0_adr;
        o_wdat   = sel ? m1_wdat : m0_wdat;

        case (state)
            IDLE: begin
                cnt_nx = '0;
`ifdef WB_ARB_ROUND_ROBIN_EN
                if (m0_cyc && m1_cyc)
                    state_nx = last ? GNT0 : GNT1;
                else if (m0_cyc)
                    state_nx = GNT0;
                else if (m1_cyc)
                    state_nx = GNT1;
`else
                if (m0_cyc)
                    state_nx = GNT0;
                else if (m1_cyc)
                    state_nx = GNT1;
`endif
            end
            GNT0, GNT1: begin
                s_cyc  = o_cyc;
                s_stb  = o_stb & ~full;
                s_we   = o_we;
                s_adr  = o_adr;
                s_wdat = o_wdat;
                accept = s_stb & ~s_stall;
                if (sel) begin
                    m1_stall = s_stall | full;
                    m1_ack   = s_ack;
                end else begin
                    m0_stall = s_stall | full;
                    m0_ack   = s_ack;
                end
                // Release may abandon outstanding transfers; their late acks land in IDLE and are dropped.
                if (!o_cyc) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    last_nx  = sel;
                end else if (accept && !s_ack) begin
                    if (!full)
                        cnt_nx = cnt + CW'(1);
                end else if (!accept && s_ack && cnt != '0) begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
